// File: rtl/nes_cpu_bus_master_pkg.sv
// Shared types and default timing for the NES CPU-side cartridge bus master.
package nes_bus_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOW  = 2'd1,
        HIGH = 2'd2
    } bus_state_e;

    localparam int unsigned DEF_LOW_CYCLES   = 6;
    localparam int unsigned DEF_HIGH_CYCLES  = 8;
    localparam int unsigned DEF_ROMSEL_DELAY = 2;
    localparam logic [15:0] DEF_IDLE_ADDR    = 16'h0000;

    // CPU address bit that qualifies /ROMSEL.
    localparam int unsigned ROMSEL_BIT = 15;

    // Phase counters count down from N-1 to 0.
    function automatic logic [7:0] phase_load(input int unsigned cycles);
        return 8'(cycles - 1);
    endfunction

endpackage

// File: rtl/nes_m2_phase_timer.sv
// Loadable 8-bit down-counter timing one M2 phase; flags the last clock of
// the phase and the clock whose count matches HIT_COUNT.
module nes_m2_phase_timer
    import nes_bus_pkg::*;
#(
    parameter logic [7:0] HIT_COUNT = phase_load(DEF_HIGH_CYCLES) - 8'(DEF_ROMSEL_DELAY)
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       i_load,
    input  logic [7:0] i_load_val,
    output logic       o_last,
    output logic       o_hit
);

    logic [7:0] r_count;

    // Load on phase entry, otherwise count down and park at zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (r_count != '0) begin
            r_count <= r_count - 8'd1;
        end
    end

    assign o_last = (r_count == '0);
    assign o_hit  = (r_count == HIT_COUNT);

endmodule

// File: rtl/nes_cpu_bus_master.sv
// NES/Famicom CPU-side cartridge bus initiator: one request -> one M2 cycle.
// Optional macro M2_FREERUN_EN: with no request pending, dummy reads of
// IDLE_ADDR keep M2 toggling instead of parking it low in IDLE.
module nes_cpu_bus_master
    import nes_bus_pkg::*;
#(
    parameter int unsigned LOW_CYCLES   = DEF_LOW_CYCLES,
    parameter int unsigned HIGH_CYCLES  = DEF_HIGH_CYCLES,
    parameter int unsigned ROMSEL_DELAY = DEF_ROMSEL_DELAY,
    parameter logic [15:0] IDLE_ADDR    = DEF_IDLE_ADDR
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_rw,
    input  logic [15:0] req_addr,
    input  logic [7:0]  req_wdata,
    output logic        resp_valid,
    output logic [7:0]  resp_rdata,
    output logic        m2,
    output logic        romsel,
    output logic        cpu_rw,
    output logic [14:0] cpu_addr,
    output logic [7:0]  cpu_data_out,
    output logic        cpu_data_oe,
    input  logic [7:0]  cpu_data_in
);

    localparam logic [7:0] LOW_LOAD  = phase_load(LOW_CYCLES);
    localparam logic [7:0] HIGH_LOAD = phase_load(HIGH_CYCLES);
    localparam logic [7:0] RS_COUNT  = 8'(HIGH_CYCLES - 1 - ROMSEL_DELAY);

    bus_state_e  r_state, w_state_nxt;
    logic        r_in_reset;
    logic        r_rw, r_dummy, r_rs_hold;
    logic [15:0] r_addr;
    logic [7:0]  r_wdata, r_rdata;
    logic [14:0] r_bus_addr;
    logic        r_bus_rw, r_resp_valid;
    logic        w_load, w_ready, w_accept, w_start_dummy, w_direct;
    logic [7:0]  w_load_val;
    logic        w_last, w_rs_hit;

    nes_m2_phase_timer #(
        .HIT_COUNT (RS_COUNT)
    ) u_timer (
        .clk        (clk),
        .reset      (reset),
        .i_load     (w_load),
        .i_load_val (w_load_val),
        .o_last     (w_last),
        .o_hit      (w_rs_hit)
    );

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_state_nxt;
    end

    // Next state, phase-timer loads, handshake and M2-phase bus strobes.
    always_comb begin
        w_state_nxt   = r_state;
        w_load        = 1'b0;
        w_load_val    = LOW_LOAD;
        w_ready       = 1'b0;
        w_start_dummy = 1'b0;
        case (r_state)
            IDLE: begin
                w_ready = !r_in_reset;
                if (req_valid && w_ready) begin
                    w_state_nxt = LOW;
                    w_load      = 1'b1;
                end
`ifdef M2_FREERUN_EN
                else if (!r_in_reset) begin
                    w_state_nxt   = LOW;
                    w_load        = 1'b1;
                    w_start_dummy = 1'b1;
                end
`endif
            end
            LOW: begin
`ifdef M2_FREERUN_EN
                w_ready = r_dummy;
`endif
                // A request landing in a dummy LOW restarts the phase.
                if (req_valid && w_ready) begin
                    w_load = 1'b1;
                end else if (w_last) begin
                    w_state_nxt = HIGH;
                    w_load      = 1'b1;
                    w_load_val  = HIGH_LOAD;
                end
            end
            HIGH: begin
                w_ready = w_last;
                if (w_last) begin
                    if (req_valid) begin
                        w_state_nxt = LOW;
                        w_load      = 1'b1;
                    end else begin
`ifdef M2_FREERUN_EN
                        w_state_nxt   = LOW;
                        w_load        = 1'b1;
                        w_start_dummy = 1'b1;
`else
                        w_state_nxt   = IDLE;
`endif
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase
        w_accept    = req_valid && w_ready;
        w_direct    = (r_state == IDLE) || ((r_state == LOW) && r_dummy);
        m2          = (r_state == HIGH);
        romsel      = !((r_state == HIGH) && r_addr[ROMSEL_BIT] && !r_dummy &&
                        (w_rs_hit || r_rs_hold));
        cpu_data_oe = !r_rw && (((r_state == LOW) && w_last) || (r_state == HIGH));
    end

    // Request latches, held bus address/RW, /ROMSEL hold and response.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_in_reset   <= 1'b1;
            r_rw         <= 1'b1;
            r_addr       <= IDLE_ADDR;
            r_wdata      <= '0;
            r_dummy      <= 1'b0;
            r_rs_hold    <= 1'b0;
            r_bus_addr   <= IDLE_ADDR[14:0];
            r_bus_rw     <= 1'b1;
            r_resp_valid <= 1'b0;
            r_rdata      <= '0;
        end else begin
            r_in_reset   <= 1'b0;
            r_resp_valid <= 1'b0;
            // Bus address lags the latch by one LOW clock so the previous
            // cycle's address/RW get a hold clock after M2 falls.
            if (w_accept && w_direct) begin
                r_bus_addr <= req_addr[14:0];
                r_bus_rw   <= req_rw;
            end else if (r_state == LOW) begin
                r_bus_addr <= r_addr[14:0];
                r_bus_rw   <= r_rw;
            end else if (r_state == IDLE) begin
                r_bus_addr <= IDLE_ADDR[14:0];
                r_bus_rw   <= 1'b1;
            end
            if ((r_state == HIGH) && w_last) begin
                r_rs_hold <= 1'b0;
                if (!r_dummy) begin
                    r_resp_valid <= 1'b1;
                    r_rdata      <= r_rw ? cpu_data_in : 8'h00;
                end
            end else if ((r_state == HIGH) && w_rs_hit) begin
                r_rs_hold <= 1'b1;
            end
            if (w_accept) begin
                r_rw    <= req_rw;
                r_addr  <= req_addr;
                r_wdata <= req_rw ? 8'h00 : req_wdata;
                r_dummy <= 1'b0;
            end else if (w_start_dummy) begin
                r_rw    <= 1'b1;
                r_addr  <= IDLE_ADDR;
                r_wdata <= '0;
                r_dummy <= 1'b1;
            end
        end
    end

    assign req_ready    = w_ready;
    assign resp_valid   = r_resp_valid;
    assign resp_rdata   = r_rdata;
    assign cpu_rw       = r_bus_rw;
    assign cpu_addr     = r_bus_addr;
    assign cpu_data_out = r_wdata;

endmodule

// File: tb/tb_nes_cpu_bus_master.sv
// Self-checking bench for nes_cpu_bus_master (default timing 6/8/2).
module tb_nes_cpu_bus_master;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_rw = 1'b1;
    logic [15:0] req_addr = 16'h0000;
    logic [7:0]  req_wdata = 8'h00;
    logic [7:0]  cpu_data_in = 8'h00;
    logic        req_ready, resp_valid, m2, romsel, cpu_rw, cpu_data_oe;
    logic [7:0]  resp_rdata, cpu_data_out;
    logic [14:0] cpu_addr;

    int checks = 0;
    int failures = 0;
    logic [7:0] exp_q[$];

    logic        c_m2[1:32], c_rs[1:32], c_oe[1:32], c_rw[1:32], c_rv[1:32], c_rdy[1:32];
    logic [14:0] c_addr[1:32];
    logic [7:0]  c_dout[1:32];

    always #5 clk = ~clk;

    nes_cpu_bus_master #(
        .LOW_CYCLES   (6),
        .HIGH_CYCLES  (8),
        .ROMSEL_DELAY (2),
        .IDLE_ADDR    (16'h0000)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_rw       (req_rw),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .resp_valid   (resp_valid),
        .resp_rdata   (resp_rdata),
        .m2           (m2),
        .romsel       (romsel),
        .cpu_rw       (cpu_rw),
        .cpu_addr     (cpu_addr),
        .cpu_data_out (cpu_data_out),
        .cpu_data_oe  (cpu_data_oe),
        .cpu_data_in  (cpu_data_in)
    );

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Called at a negedge; returns at the negedge of the first LOW clock.
    task automatic issue(input logic rw, input logic [15:0] a, input logic [7:0] wd,
                         input logic [7:0] din, input bit push);
        int n;
        req_rw = rw; req_addr = a; req_wdata = wd; cpu_data_in = din; req_valid = 1'b1;
        n = 0;
        while (!req_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            checks++; failures++;
            $display("FAIL issue_timeout: req_ready=%0b required 1", req_ready);
        end
        if (push) exp_q.push_back(rw ? din : 8'h00);
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    // Samples clocks 1..n of a cycle; pops the scoreboard on each response.
    task automatic capture(input int n);
        logic [7:0] e;
        for (int k = 1; k <= n; k++) begin
            c_m2[k] = m2; c_rs[k] = romsel; c_oe[k] = cpu_data_oe; c_rw[k] = cpu_rw;
            c_rv[k] = resp_valid; c_rdy[k] = req_ready; c_addr[k] = cpu_addr;
            c_dout[k] = cpu_data_out;
            if (resp_valid) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL sb_unexpected_resp: rdata=%h with empty scoreboard", resp_rdata);
                end else begin
                    e = exp_q.pop_front();
                    if (resp_rdata !== e) begin
                        failures++;
                        $display("FAIL sb_rdata: got %h expected %h", resp_rdata, e);
                    end
                end
            end
            if (k < n) @(negedge clk);
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (m2 !== 1'b0) begin failures++; $display("FAIL rst_m2: got %b expected 0", m2); end
        checks++; if (romsel !== 1'b1) begin failures++; $display("FAIL rst_romsel: got %b expected 1", romsel); end
        checks++; if (cpu_rw !== 1'b1) begin failures++; $display("FAIL rst_rw: got %b expected 1", cpu_rw); end
        checks++; if (cpu_addr !== 15'h0000) begin failures++; $display("FAIL rst_addr: got %h expected 0000", cpu_addr); end
        checks++; if ({cpu_data_oe, cpu_data_out} !== 9'h000) begin failures++; $display("FAIL rst_data: got oe=%b out=%h expected 0/00", cpu_data_oe, cpu_data_out); end
        checks++; if ({req_ready, resp_valid, resp_rdata} !== 10'h000) begin failures++; $display("FAIL rst_handshake: got rdy=%b rv=%b rd=%h expected 0/0/00", req_ready, resp_valid, resp_rdata); end
        reset = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_rom_write;
        int first_oe, n_oe, first_rs, n_rs, first_m2, n_m2, rv_at, n_rv, bad_dout, bad_rw, n_rdy;
        first_oe = 0; n_oe = 0; first_rs = 0; n_rs = 0; first_m2 = 0; n_m2 = 0;
        rv_at = 0; n_rv = 0; bad_dout = 0; bad_rw = 0; n_rdy = 0;
        issue(1'b0, 16'h8000, 8'hA5, 8'h00, 1'b1);
        capture(16);
        for (int k = 1; k <= 16; k++) begin
            if (c_oe[k])  begin n_oe++; if (first_oe == 0) first_oe = k; end
            if (!c_rs[k]) begin n_rs++; if (first_rs == 0) first_rs = k; end
            if (c_m2[k])  begin n_m2++; if (first_m2 == 0) first_m2 = k; end
            if (c_rv[k])  begin n_rv++; rv_at = k; end
            if (k <= 14 && c_dout[k] !== 8'hA5) bad_dout++;
            if (k <= 15 && c_rw[k] !== 1'b0) bad_rw++;
            if (k <= 13 && c_rdy[k]) n_rdy++;
        end
        checks++; if (first_oe != 6) begin failures++; $display("FAIL wr_oe_first: got %0d expected 6", first_oe); end
        checks++; if (n_oe != 9) begin failures++; $display("FAIL wr_oe_len: got %0d expected 9", n_oe); end
        checks++; if (first_rs != 9) begin failures++; $display("FAIL wr_romsel_first: got %0d expected 9", first_rs); end
        checks++; if (n_rs != 6) begin failures++; $display("FAIL wr_romsel_len: got %0d expected 6", n_rs); end
        checks++; if (first_m2 != 7 || n_m2 != 8) begin failures++; $display("FAIL wr_m2: got first=%0d len=%0d expected 7/8", first_m2, n_m2); end
        checks++; if (rv_at != 15 || n_rv != 1) begin failures++; $display("FAIL wr_resp_time: got at=%0d n=%0d expected 15/1", rv_at, n_rv); end
        checks++; if (bad_dout != 0) begin failures++; $display("FAIL wr_dout: got %0d bad clocks expected 0", bad_dout); end
        checks++; if (bad_rw != 0 || c_rw[16] !== 1'b1) begin failures++; $display("FAIL wr_rw_hold: got bad=%0d rw16=%b expected 0/1", bad_rw, c_rw[16]); end
        checks++; if (n_rdy != 0 || c_rdy[14] !== 1'b1) begin failures++; $display("FAIL wr_ready: got early=%0d last=%b expected 0/1", n_rdy, c_rdy[14]); end
    endtask

    task automatic test_rom_read;
        int bad_addr, bad_rw, n_oe, first_rs;
        bad_addr = 0; bad_rw = 0; n_oe = 0; first_rs = 0;
        issue(1'b1, 16'hC123, 8'hEE, 8'h5A, 1'b1);
        capture(16);
        for (int k = 1; k <= 16; k++) begin
            if (k <= 15 && c_addr[k] !== 15'h4123) bad_addr++;
            if (c_rw[k] !== 1'b1) bad_rw++;
            if (c_oe[k]) n_oe++;
            if (!c_rs[k] && first_rs == 0) first_rs = k;
        end
        checks++; if (bad_addr != 0 || c_addr[16] !== 15'h0000) begin failures++; $display("FAIL rd_addr: got bad=%0d addr16=%h expected 0/0000", bad_addr, c_addr[16]); end
        checks++; if (bad_rw != 0) begin failures++; $display("FAIL rd_rw: got %0d bad clocks expected 0", bad_rw); end
        checks++; if (n_oe != 0) begin failures++; $display("FAIL rd_oe: got %0d oe clocks expected 0", n_oe); end
        checks++; if (first_rs != 9) begin failures++; $display("FAIL rd_romsel_first: got %0d expected 9", first_rs); end
    endtask

    task automatic test_ram_write;
        int n_rs, n_m2, bad_addr;
        n_rs = 0; n_m2 = 0; bad_addr = 0;
        issue(1'b0, 16'h6000, 8'h01, 8'h00, 1'b1);
        capture(16);
        for (int k = 1; k <= 16; k++) begin
            if (!c_rs[k]) n_rs++;
            if (c_m2[k]) n_m2++;
            if (k <= 15 && c_addr[k] !== 15'h6000) bad_addr++;
        end
        checks++; if (n_rs != 0) begin failures++; $display("FAIL ram_romsel: got %0d low clocks expected 0", n_rs); end
        checks++; if (n_m2 != 8) begin failures++; $display("FAIL ram_m2_len: got %0d expected 8", n_m2); end
        checks++; if (bad_addr != 0) begin failures++; $display("FAIL ram_addr: got %0d bad clocks expected 0", bad_addr); end
    endtask

    task automatic test_back_to_back;
        logic [15:0] addrs[3];
        logic [7:0]  dins[3];
        logic [14:0] tr_addr[0:99];
        int acc_t[3], resp_t[3];
        int nacc, nresp;
        bit pend;
        logic [7:0] e;
        addrs[0] = 16'hC000; addrs[1] = 16'h8001; addrs[2] = 16'hFFFC;
        dins[0] = 8'h11; dins[1] = 8'h22; dins[2] = 8'h33;
        for (int i = 0; i < 3; i++) begin acc_t[i] = 0; resp_t[i] = 0; end
        nacc = 0; nresp = 0; pend = 1'b0;
        req_rw = 1'b1; req_addr = addrs[0]; cpu_data_in = dins[0]; req_valid = 1'b1;
        for (int t = 0; t < 100 && nresp < 3; t++) begin
            if (t > 0) @(negedge clk);
            tr_addr[t] = cpu_addr;
            if (resp_valid) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL b2b_unexpected_resp: rdata=%h with empty scoreboard", resp_rdata);
                end else begin
                    e = exp_q.pop_front();
                    if (resp_rdata !== e) begin failures++; $display("FAIL b2b_rdata: got %h expected %h", resp_rdata, e); end
                end
                if (nresp < 3) resp_t[nresp] = t;
                nresp++;
            end
            if (pend) begin
                pend = 1'b0;
                cpu_data_in = dins[nacc];
                exp_q.push_back(dins[nacc]);
                acc_t[nacc] = t;
                nacc++;
                if (nacc < 3) req_addr = addrs[nacc];
                else req_valid = 1'b0;
            end
            if (req_valid && req_ready) pend = 1'b1;
        end
        req_valid = 1'b0;
        checks++; if (nresp != 3) begin failures++; $display("FAIL b2b_resp_count: got %0d expected 3", nresp); end
        checks++; if (acc_t[1] - acc_t[0] != 14 || acc_t[2] - acc_t[1] != 14) begin failures++; $display("FAIL b2b_period: got %0d,%0d expected 14,14", acc_t[1] - acc_t[0], acc_t[2] - acc_t[1]); end
        checks++; if (resp_t[1] - resp_t[0] != 14 || resp_t[2] - resp_t[1] != 14 || resp_t[0] - acc_t[0] != 14) begin failures++; $display("FAIL b2b_resp_spacing: got %0d,%0d lat=%0d expected 14,14,14", resp_t[1] - resp_t[0], resp_t[2] - resp_t[1], resp_t[0] - acc_t[0]); end
        checks++; if (tr_addr[acc_t[1]] !== 15'h4000 || tr_addr[acc_t[1] + 1] !== 15'h0001) begin failures++; $display("FAIL b2b_addr_switch: got %h,%h expected 4000,0001", tr_addr[acc_t[1]], tr_addr[acc_t[1] + 1]); end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset_midcycle;
        int n_rv;
        n_rv = 0;
        issue(1'b0, 16'h8000, 8'h3C, 8'h00, 1'b0);
        repeat (9) @(negedge clk);
        checks++; if (romsel !== 1'b0 || m2 !== 1'b1) begin failures++; $display("FAIL mid_pre: got romsel=%b m2=%b expected 0/1", romsel, m2); end
        reset = 1'b1;
        @(negedge clk);
        checks++; if ({m2, romsel, cpu_data_oe} !== 3'b010) begin failures++; $display("FAIL mid_reset_vals: got m2=%b romsel=%b oe=%b expected 0/1/0", m2, romsel, cpu_data_oe); end
        reset = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (resp_valid) n_rv++;
            @(negedge clk);
        end
        checks++; if (n_rv != 0) begin failures++; $display("FAIL mid_no_resp: got %0d responses expected 0", n_rv); end
    endtask

`ifdef M2_FREERUN_EN
    task automatic test_freerun;
        int run, ntrans, bad_run, n_rs, n_rv;
        logic prev;
        bit seen;
        run = 1; ntrans = 0; bad_run = 0; n_rs = 0; n_rv = 0; seen = 1'b0;
        prev = m2;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (!romsel) n_rs++;
            if (resp_valid) n_rv++;
            if (m2 === prev) begin
                run++;
            end else begin
                if (seen && run != (prev ? 8 : 6)) bad_run++;
                seen = 1'b1;
                ntrans++;
                run = 1;
                prev = m2;
            end
        end
        checks++; if (bad_run != 0 || ntrans < 12) begin failures++; $display("FAIL fr_pattern: got bad=%0d transitions=%0d expected 0/>=12", bad_run, ntrans); end
        checks++; if (n_rs != 0) begin failures++; $display("FAIL fr_romsel: got %0d low clocks expected 0", n_rs); end
        checks++; if (n_rv != 0) begin failures++; $display("FAIL fr_resp: got %0d responses expected 0", n_rv); end
    endtask
`else
    task automatic test_idle_quiet;
        int n_m2, n_rs;
        n_m2 = 0; n_rs = 0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (m2) n_m2++;
            if (!romsel) n_rs++;
        end
        checks++; if (n_m2 != 0 || n_rs != 0) begin failures++; $display("FAIL idle_quiet: got m2 high=%0d romsel low=%0d expected 0/0", n_m2, n_rs); end
    endtask
`endif

    initial begin
        @(negedge clk);
        test_reset;
        test_rom_write;
        test_rom_read;
        test_ram_write;
        test_back_to_back;
        test_reset_midcycle;
`ifdef M2_FREERUN_EN
        test_freerun;
`else
        test_idle_quiet;
`endif
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL sb_leftover: got %0d pending expected 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
